// File: rtl/wb_trace_fifo.sv
// Commit-trace capture FIFO: records register-writing instructions from the
// writeback stage and presents them show-ahead to a consumer, dropping on full.
module wb_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     trace_en,
    input  logic [31:0]              debug_wb_pc,
    input  logic [3:0]               debug_wb_rf_wen,
    input  logic [4:0]               debug_wb_rf_wnum,
    input  logic [31:0]              debug_wb_rf_wdata,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_pc,
    output logic [3:0]               trace_wen,
    output logic [4:0]               trace_wnum,
    output logic [31:0]              trace_wdata,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     overflow,
    output logic [CW-1:0]            overflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [CW-1:0]   ovf_cnt_q, ovf_cnt_d;

    logic            push, pop, wr_en, drop;
    entry_t          entry_in, head;

    assign entry_in = '{pc: debug_wb_pc, wen: debug_wb_rf_wen,
                        wnum: debug_wb_rf_wnum, wdata: debug_wb_rf_wdata};

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == FULL_CNT);
    assign trace_valid = !fifo_empty;

    assign push  = trace_en && (debug_wb_rf_wen != 4'b0000);
    assign pop   = trace_valid && trace_ready;
    // When full, the slot under the write pointer is the head; it may only be
    // overwritten in the same cycle it is being popped.
    assign wr_en = push && (!fifo_full || pop);
    assign drop  = push && fifo_full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
            if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= entry_in;
    end

    assign head         = mem_q[rd_ptr_q];
    assign trace_pc     = head.pc;
    assign trace_wen    = head.wen;
    assign trace_wnum   = head.wnum;
    assign trace_wdata  = head.wdata;
    assign fifo_count   = count_q;
    assign overflow     = overflow_q;
    assign overflow_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo: capture, show-ahead drain, overflow,
// saturation (narrow counter instance) and asynchronous reset.
module tb_wb_trace_fifo;

    localparam int DEPTH = 16;
    localparam int CW    = 2;

    logic        clk;
    logic        resetn;
    logic        trace_en;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [3:0]  trace_wen;
    logic [4:0]  trace_wnum;
    logic [31:0] trace_wdata;
    logic [4:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overflow;
    logic [CW-1:0] overflow_cnt;

    int errors = 0;
    int checks = 0;

    wb_trace_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .trace_en          (trace_en),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .trace_valid       (trace_valid),
        .trace_ready       (trace_ready),
        .trace_pc          (trace_pc),
        .trace_wen         (trace_wen),
        .trace_wnum        (trace_wnum),
        .trace_wdata       (trace_wdata),
        .fifo_count        (fifo_count),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .overflow          (overflow),
        .overflow_cnt      (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [3:0] wen,
                         input logic [4:0] wnum, input logic [31:0] wdata);
        debug_wb_pc       = pc;
        debug_wb_rf_wen   = wen;
        debug_wb_rf_wnum  = wnum;
        debug_wb_rf_wdata = wdata;
    endtask

    task automatic idle();
        drive(32'h0, 4'h0, 5'd0, 32'h0);
    endtask

    // Fill 16 entries with pc = base + 4*i, wnum = i, wdata = ~pc, ready held low.
    task automatic fill(input logic [31:0] base);
        trace_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(base + 32'(4 * i), 4'hF, 5'(i), ~(base + 32'(4 * i)));
            step();
        end
        idle();
    endtask

    initial begin
        resetn = 1'b0; trace_en = 1'b1; trace_ready = 1'b0;
        idle();
        #1;
        check("rst_count", fifo_count, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_valid", trace_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ovf_cnt", overflow_cnt, 0);
        step(); step();
        resetn = 1'b1;
        step();

        // Single push, held while not ready
        drive(32'hBFC0_0000, 4'hF, 5'd2, 32'h0000_1234);
        step();
        idle();
        check("single_valid", trace_valid, 1);
        check("single_pc", trace_pc, 32'hBFC0_0000);
        check("single_wen", trace_wen, 4'hF);
        check("single_wnum", trace_wnum, 2);
        check("single_wdata", trace_wdata, 32'h0000_1234);
        check("single_count", fifo_count, 1);
        for (int c = 0; c < 5; c++) begin
            step();
            check("hold_pc", trace_pc, 32'hBFC0_0000);
            check("hold_wdata", trace_wdata, 32'h0000_1234);
        end
        trace_ready = 1'b1;
        step();
        check("single_drained", fifo_empty, 1);

        // Fill, overflow by one, drain in order
        fill(32'h8000_0000);
        check("fill_full", fifo_full, 1);
        check("fill_count", fifo_count, 16);
        drive(32'hDEAD_BEEF, 4'h1, 5'd31, 32'h0BAD_0BAD);
        step();
        idle();
        check("drop_ovf", overflow, 1);
        check("drop_ovf_cnt", overflow_cnt, 1);
        check("drop_count", fifo_count, 16);
        trace_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_pc", trace_pc, 32'h8000_0000 + 32'(4 * i));
            check("drain_wnum", trace_wnum, 5'(i));
            step();
        end
        check("drain_empty", fifo_empty, 1);

        // Full with simultaneous push and pop: no drop
        fill(32'h9000_0000);
        trace_ready = 1'b1;
        drive(32'h9999_0000, 4'h3, 5'd0, 32'h5A5A_5A5A);
        step();
        idle();
        check("fullpp_count", fifo_count, 16);
        check("fullpp_ovf_cnt", overflow_cnt, 1);
        for (int i = 1; i < DEPTH; i++) begin
            check("fullpp_pc", trace_pc, 32'h9000_0000 + 32'(4 * i));
            step();
        end
        check("fullpp_last_pc", trace_pc, 32'h9999_0000);
        check("fullpp_last_wnum", trace_wnum, 0);
        check("fullpp_last_wen", trace_wen, 4'h3);
        step();
        check("fullpp_empty", fifo_empty, 1);

        // Streaming through with ready high across pointer wrap
        trace_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) check("stream_pc", trace_pc, 32'hC000_0000 + 32'(i - 1));
            drive(32'hC000_0000 + 32'(i), 4'hF, 5'(i), 32'(i));
            step();
            check("stream_count", fifo_count, 1);
        end
        idle();
        check("stream_last_pc", trace_pc, 32'hC000_0027);
        check("stream_last_wdata", trace_wdata, 39);
        step();
        check("stream_empty", fifo_empty, 1);

        // Non-captures
        trace_ready = 1'b0;
        trace_en = 1'b1;
        drive(32'h1111_1111, 4'h0, 5'd3, 32'h1);
        step();
        check("wen0_count", fifo_count, 0);
        trace_en = 1'b0;
        drive(32'h2222_2222, 4'hF, 5'd4, 32'h2);
        step();
        check("en0_count", fifo_count, 0);
        trace_en = 1'b1;
        idle();

        // Counter saturation at 3, then partial drain with capture disabled
        fill(32'hA000_0000);
        drive(32'hEEEE_0000, 4'hF, 5'd1, 32'h0);
        step();
        check("sat_cnt2", overflow_cnt, 2);
        step();
        check("sat_cnt3", overflow_cnt, 3);
        step();
        check("sat_hold", overflow_cnt, 3);
        check("sat_count", fifo_count, 16);
        check("sat_head", trace_pc, 32'hA000_0000);
        trace_en = 1'b0;
        trace_ready = 1'b1;
        for (int i = 0; i < 9; i++) step();
        trace_ready = 1'b0;
        check("en0_drain_count", fifo_count, 7);
        check("en0_drain_head", trace_pc, 32'hA000_0024);
        check("pre_rst_ovf", overflow, 1);

        // Asynchronous reset mid-cycle
        #2;
        resetn = 1'b0;
        #1;
        check("arst_count", fifo_count, 0);
        check("arst_valid", trace_valid, 0);
        check("arst_ovf", overflow, 0);
        check("arst_ovf_cnt", overflow_cnt, 0);
        step();
        resetn = 1'b1;
        trace_en = 1'b1;
        drive(32'h5555_0000, 4'h8, 5'd9, 32'h7777_7777);
        step();
        idle();
        check("post_rst_pc", trace_pc, 32'h5555_0000);
        check("post_rst_wdata", trace_wdata, 32'h7777_7777);
        check("post_rst_count", fifo_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_trace_fifo.md
WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 2..256.
REQ-002 Parameter CW, default 16, width of overflow_cnt.
REQ-003 clk  input  1  sole clock; all state SHALL change on rising edge only.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 trace_en  input  1  capture enable; 0 blocks pushes.
REQ-006 debug_wb_pc  input  32  PC of committing instruction.
REQ-007 debug_wb_rf_wen  input  4  byte write enables; nonzero marks a register write.
REQ-008 debug_wb_rf_wnum  input  5  destination register number.
REQ-009 debug_wb_rf_wdata  input  32  write data.
REQ-010 trace_valid  output  1  head entry available.
REQ-011 trace_ready  input  1  consumer accepts head entry.
REQ-012 trace_pc, trace_wen, trace_wnum, trace_wdata  output  32/4/5/32  head entry fields.
REQ-013 fifo_count  output  log2(DEPTH)+1  entries held.
REQ-014 fifo_full, fifo_empty  output  1  count==DEPTH, count==0.
REQ-015 overflow  output  1  sticky; an entry has been dropped.
REQ-016 overflow_cnt  output  CW  dropped-entry count.

Function
REQ-017 push SHALL be trace_en && (debug_wb_rf_wen != 0); wnum 0 SHALL be captured like any other register.
REQ-018 pop SHALL be trace_valid && trace_ready; trace_valid SHALL equal !fifo_empty.
REQ-019 Head fields SHALL be show-ahead: trace_* driven from the entry at the read pointer with no extra read latency.
REQ-020 Latency: an entry pushed at edge N SHALL appear on trace_* with trace_valid=1 after edge N when the FIFO was empty.
REQ-021 trace_* SHALL hold stable while trace_valid && !trace_ready.
REQ-022 Order SHALL be strict FIFO; read and write pointers SHALL wrap modulo DEPTH.
REQ-023 Empty with push: entry written; a pop cannot occur that cycle; count goes 0->1.
REQ-024 Push and pop in the same cycle, not full: both occur; count unchanged.
REQ-025 Full with push and pop in the same cycle: both occur, no drop, count stays DEPTH.
REQ-026 Full with push and no pop: entry dropped, FIFO contents unchanged, overflow set, overflow_cnt incremented.
REQ-027 overflow_cnt SHALL saturate at 2^CW-1 with no wrap.
REQ-028 overflow SHALL clear only on reset.
REQ-029 trace_en=0 SHALL not affect pops or the drain of stored entries.
REQ-030 The block SHALL apply no backpressure upstream; the CPU never stalls on it.

Reset
REQ-031 resetn=0 SHALL, asynchronously, set both pointers to 0, fifo_count=0, fifo_empty=1, fifo_full=0, trace_valid=0, overflow=0 and overflow_cnt=0.
REQ-032 While resetn=0, trace_pc/wen/wnum/wdata value is don't-care; storage array need not be reset.
REQ-033 Reset mid-operation SHALL discard all stored entries; the first push after deassertion SHALL be the new head.
REQ-034 Deassertion SHALL be honoured on the next rising edge; a push in the first cycle after release SHALL be captured.

Verification
REQ-035 Single push with pc=0xBFC00000, wen=0xF, wnum=2, wdata=0x1234 and ready=0 -> next cycle valid=1 with these fields, count=1; held unchanged for 5 cycles.
REQ-036 Push 16 distinct entries with ready=0 -> full=1, count=16; a 17th push -> overflow=1, overflow_cnt=1, count=16; drain -> the original 16 entries in order.
REQ-037 Full, then push with ready=1 in one cycle -> no drop, overflow_cnt unchanged, the new entry appears last.
REQ-038 Continuous push with ready=1 for 40 cycles -> count stays at 1 after the first cycle; all 40 entries out in order across pointer wrap.
REQ-039 Pushes with wen=0 or trace_en=0 -> nothing captured, count unchanged.
REQ-040 Reset asserted with count=7 and overflow=1 -> immediately count=0, valid=0, overflow=0, overflow_cnt=0; a push after release -> head equals that push.
